// File: rtl/cache_arbiter_if.sv
// rtl/cache_arbiter_if.sv - line-sized physical-memory handshake bundle
// master drives the command side, slave returns data and completion.
interface cache_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin arbiter sharing one pmem port between I-cache and D-cache
// The winner's command is latched at grant time and held until pmem_resp.
module cache_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cache_arbiter_if.slave        i_bus,
  cache_arbiter_if.slave        d_bus,
  cache_arbiter_if.master       mem_bus,
  output logic                  arb_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic              cmd_rd;
  logic              cmd_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;
  logic busy;

  // The I-cache never writes; its write-side members are intentionally ignored.
  logic unused_i_side;
  assign unused_i_side = &{1'b0, i_bus.pmem_write, i_bus.pmem_wdata};

  assign i_req = i_bus.pmem_read;
  assign d_req = d_bus.pmem_read | d_bus.pmem_write;
  assign busy  = (state != IDLE);

  // On a tie the side opposite last_grant wins, so continuous contention alternates.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
      grant_d = d_req & (~i_req | ~last_grant);
      grant_i = i_req & ~grant_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt = D_BUSY;
        end else if (grant_i) begin
          state_nxt = I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_bus.pmem_resp) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b0;
      cmd_rd     <= 1'b0;
      cmd_wr     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (grant_d) begin
      addr_q     <= d_bus.pmem_address;
      wdata_q    <= d_bus.pmem_wdata;
      cmd_wr     <= d_bus.pmem_write;
      cmd_rd     <= d_bus.pmem_read & ~d_bus.pmem_write;
      last_grant <= 1'b1;
    end else if (grant_i) begin
      addr_q     <= i_bus.pmem_address;
      cmd_rd     <= 1'b1;
      cmd_wr     <= 1'b0;
      last_grant <= 1'b0;
    end else if (busy && mem_bus.pmem_resp) begin
      cmd_rd <= 1'b0;
      cmd_wr <= 1'b0;
    end
  end

  // Read data is shared by both requesters; only the resp strobe qualifies it.
  always_comb begin
    mem_bus.pmem_read    = busy & cmd_rd;
    mem_bus.pmem_write   = busy & cmd_wr;
    mem_bus.pmem_address = addr_q;
    mem_bus.pmem_wdata   = wdata_q;
    i_bus.pmem_resp      = (state == I_BUSY) & mem_bus.pmem_resp;
    d_bus.pmem_resp      = (state == D_BUSY) & mem_bus.pmem_resp;
    i_bus.pmem_rdata     = rst_n ? mem_bus.pmem_rdata : '0;
    d_bus.pmem_rdata     = rst_n ? mem_bus.pmem_rdata : '0;
    arb_busy             = busy;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - directed and randomized check of cache_arbiter against a transaction-level model
module tb_cache_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;

  logic clk = 1'b0;
  logic rst_n;
  logic arb_busy;

  always #5 clk = ~clk;

  cache_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) i_bus ();
  cache_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) d_bus ();
  cache_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) mem_bus ();

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_bus    (i_bus),
    .d_bus    (d_bus),
    .mem_bus  (mem_bus),
    .arb_busy (arb_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: who owns memory (0 none, 1 I, 2 D), the command it holds, and the tie-break history.
  int          m_owner;
  bit          m_rd, m_wr, m_last;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  bit          i_seen, d_seen;
  int          mem_cnt;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_rd = 0; m_wr = 0; m_last = 0; m_addr = '0; m_wdata = '0;
  endtask

  task automatic model_edge();
    bit ir, dr, pick_d;
    if (!rst_n) begin
      model_reset();
    end else if (m_owner == 0) begin
      ir = i_bus.pmem_read;
      dr = d_bus.pmem_read | d_bus.pmem_write;
      pick_d = dr && (!ir || !m_last);
      if (pick_d) begin
        m_owner = 2; m_last = 1;
        m_addr = d_bus.pmem_address; m_wdata = d_bus.pmem_wdata;
        m_wr = d_bus.pmem_write; m_rd = d_bus.pmem_read && !d_bus.pmem_write;
      end else if (ir) begin
        m_owner = 1; m_last = 0;
        m_addr = i_bus.pmem_address; m_rd = 1; m_wr = 0;
      end
    end else if (mem_bus.pmem_resp) begin
      m_owner = 0; m_rd = 0; m_wr = 0;
    end
  endtask

  task automatic sample();
    logic [LW-1:0] rd_exp;
    #1;
    rd_exp = rst_n ? mem_bus.pmem_rdata : '0;
    check("pmem_read", mem_bus.pmem_read, (m_owner != 0) && m_rd);
    check("pmem_write", mem_bus.pmem_write, (m_owner != 0) && m_wr);
    check("pmem_address", mem_bus.pmem_address, m_addr);
    check("pmem_wdata", mem_bus.pmem_wdata, m_wdata);
    check("i_resp", i_bus.pmem_resp, (m_owner == 1) && mem_bus.pmem_resp);
    check("d_resp", d_bus.pmem_resp, (m_owner == 2) && mem_bus.pmem_resp);
    check("i_rdata", i_bus.pmem_rdata, rd_exp);
    check("d_rdata", d_bus.pmem_rdata, rd_exp);
    check("arb_busy", arb_busy, m_owner != 0);
    i_seen = i_bus.pmem_resp;
    d_seen = d_bus.pmem_resp;
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic rand_drive();
    int k;
    if (i_bus.pmem_read) begin
      if (i_seen) i_bus.pmem_read = 1'b0;
      else if ($urandom_range(0, 3) == 0) i_bus.pmem_address = AW'($urandom);
    end else if ($urandom_range(0, 2) == 0) begin
      i_bus.pmem_read = 1'b1;
      i_bus.pmem_address = AW'($urandom);
    end
    if (d_bus.pmem_read || d_bus.pmem_write) begin
      if (d_seen) begin
        d_bus.pmem_read = 1'b0; d_bus.pmem_write = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        d_bus.pmem_address = AW'($urandom);
        d_bus.pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end else if ($urandom_range(0, 2) == 0) begin
      k = $urandom_range(0, 4);
      d_bus.pmem_read  = (k <= 1) || (k == 4);
      d_bus.pmem_write = (k >= 2);
      d_bus.pmem_address = AW'($urandom);
      d_bus.pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
    end
    mem_bus.pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
    mem_bus.pmem_resp = 1'b0;
    if (m_owner != 0) begin
      if (mem_cnt == 0) begin
        mem_bus.pmem_resp = 1'b1;
        mem_cnt = $urandom_range(0, 3);
      end else begin
        mem_cnt--;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      mem_bus.pmem_resp = 1'b1;
    end
  endtask

  int exp_side[4] = '{2, 1, 2, 1};

  initial begin
    rst_n = 1'b0;
    i_bus.pmem_read = 0; i_bus.pmem_write = 0; i_bus.pmem_address = '0; i_bus.pmem_wdata = '0;
    d_bus.pmem_read = 0; d_bus.pmem_write = 0; d_bus.pmem_address = '0; d_bus.pmem_wdata = '0;
    mem_bus.pmem_resp = 0; mem_bus.pmem_rdata = '0;
    i_seen = 0; d_seen = 0; mem_cnt = 0;
    model_reset();
    @(negedge clk);
    sample(); advance();
    sample(); advance();
    rst_n = 1'b1;

    // Single I read, response in cycle 5.
    i_bus.pmem_read = 1; i_bus.pmem_address = 16'h1230;
    sample(); advance();
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) begin
        mem_bus.pmem_resp = 1;
        mem_bus.pmem_rdata = 128'hDEADBEEF_00000000_00000000_00000001;
      end
      sample();
      check("iread_rd", mem_bus.pmem_read, 1'b1);
      check("iread_addr", mem_bus.pmem_address, 16'h1230);
      check("iread_iresp", i_bus.pmem_resp, c == 5);
      check("iread_dresp", d_bus.pmem_resp, 1'b0);
      advance();
    end
    check("iread_data", i_bus.pmem_rdata, 128'hDEADBEEF_00000000_00000000_00000001);
    i_bus.pmem_read = 0; mem_bus.pmem_resp = 0;
    sample();
    check("iread_done", mem_bus.pmem_read, 1'b0);
    advance();

    // D write-back.
    d_bus.pmem_write = 1; d_bus.pmem_address = 16'h4440; d_bus.pmem_wdata = {16{8'hA5}};
    sample(); advance();
    for (int c = 1; c <= 4; c++) begin
      mem_bus.pmem_resp = (c == 4);
      sample();
      check("dwb_wr", mem_bus.pmem_write, 1'b1);
      check("dwb_rd", mem_bus.pmem_read, 1'b0);
      check("dwb_wdata", mem_bus.pmem_wdata, {16{8'hA5}});
      check("dwb_dresp", d_bus.pmem_resp, c == 4);
      advance();
    end
    d_bus.pmem_write = 0; mem_bus.pmem_resp = 0;
    sample();
    check("dwb_resp_once", d_bus.pmem_resp, 1'b0);
    advance();

    // D read and write together: write wins.
    d_bus.pmem_read = 1; d_bus.pmem_write = 1; d_bus.pmem_address = 16'h0080;
    sample(); advance();
    sample();
    check("drw_wr", mem_bus.pmem_write, 1'b1);
    check("drw_rd", mem_bus.pmem_read, 1'b0);
    advance();
    mem_bus.pmem_resp = 1; sample(); advance();
    d_bus.pmem_read = 0; d_bus.pmem_write = 0; mem_bus.pmem_resp = 0;
    sample(); advance();

    // Latch stability while I is busy.
    i_bus.pmem_read = 1; i_bus.pmem_address = 16'h2000;
    sample(); advance();
    i_bus.pmem_address = 16'hFFFE;
    d_bus.pmem_read = 1; d_bus.pmem_address = 16'h3000;
    for (int c = 0; c < 3; c++) begin
      mem_bus.pmem_resp = (c == 2);
      sample();
      check("latch_addr", mem_bus.pmem_address, 16'h2000);
      check("latch_dresp", d_bus.pmem_resp, 1'b0);
      advance();
    end
    i_bus.pmem_read = 0; mem_bus.pmem_resp = 0;
    sample();
    check("latch_idle", arb_busy, 1'b0);
    advance();
    sample();
    check("latch_dgrant", mem_bus.pmem_address, 16'h3000);
    advance();
    mem_bus.pmem_resp = 1; sample(); advance();
    d_bus.pmem_read = 0; mem_bus.pmem_resp = 0;
    sample(); advance();

    // Reset in the middle of a D write.
    d_bus.pmem_write = 1; d_bus.pmem_address = 16'h5550; d_bus.pmem_wdata = {4{32'h12345678}};
    sample(); advance();
    sample();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_async_wr", mem_bus.pmem_write, 1'b0);
    check("rst_async_addr", mem_bus.pmem_address, 16'h0000);
    check("rst_async_wdata", mem_bus.pmem_wdata, '0);
    check("rst_async_busy", arb_busy, 1'b0);
    d_bus.pmem_write = 0;
    advance();
    rst_n = 1'b1;
    mem_bus.pmem_resp = 1;
    sample();
    check("rst_stale_dresp", d_bus.pmem_resp, 1'b0);
    advance();
    mem_bus.pmem_resp = 0;

    // Continuous contention right after reset alternates D, I, D, I.
    i_bus.pmem_read = 1; i_bus.pmem_address = 16'h0100;
    d_bus.pmem_read = 1; d_bus.pmem_address = 16'h0200;
    sample(); advance();
    for (int t = 0; t < 4; t++) begin
      sample();
      check("rr_addr", mem_bus.pmem_address, (exp_side[t] == 2) ? 16'h0200 : 16'h0100);
      advance();
      mem_bus.pmem_resp = 1;
      sample();
      check("rr_dresp", d_bus.pmem_resp, exp_side[t] == 2);
      check("rr_iresp", i_bus.pmem_resp, exp_side[t] == 1);
      advance();
      mem_bus.pmem_resp = 0;
      sample();
      check("rr_gap", arb_busy, 1'b0);
      advance();
    end
    i_bus.pmem_read = 0; d_bus.pmem_read = 0;
    sample(); advance();

    // Randomized traffic.
    i_seen = 0; d_seen = 0;
    for (int n = 0; n < 3000; n++) begin
      rand_drive();
      sample();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
